// File: rtl/gsm_ts_ctrl.sv
// GSM time-share filter controller: IDLE/SYNC/RUN phase sequencer
// with double-banked symmetric coefficient store and glitch-free swap.
module gsm_ts_ctrl #(
   parameter int WIDTH = 18,
   parameter int NCOEF = 51,
   parameter int AW    = 6
) (
   input  logic                    sys_clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [AW-1:0]           cfg_addr,
   input  logic signed [WIDTH-1:0] cfg_data,
   input  logic                    cfg_commit,
   input  logic [AW-1:0]           rd_addr,
   output logic signed [WIDTH-1:0] rd_data,
   output logic                    sam_clk_en,
   output logic [1:0]              phase,
   output logic                    acc_clr,
   output logic                    bank_sel,
   output logic                    cfg_err
);

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      RUN
   } state_t;

   localparam logic [AW:0] NC_LIM = (AW+1)'(NCOEF);

   state_t state_q, state_d;
   logic [1:0] phase_q, phase_d;
   logic bank_sel_q, bank_sel_d;
   logic pend_q, pend_d;
   logic err_q, err_d;
   logic signed [WIDTH-1:0] bank_q [2][NCOEF];
   logic signed [WIDTH-1:0] bank_d [2][NCOEF];

   logic wr_hs, wr_ok, rd_ok, swap;

   assign cfg_ready  = ~pend_q;
   assign phase      = phase_q;
   assign bank_sel   = bank_sel_q;
   assign cfg_err    = err_q;
   assign sam_clk_en = (state_q == RUN) && (phase_q == 2'd3);
   assign acc_clr    = sam_clk_en;

   assign wr_hs = cfg_valid & cfg_ready;
   assign wr_ok = ({1'b0, cfg_addr} < NC_LIM);
   assign rd_ok = ({1'b0, rd_addr} < NC_LIM);

   // Swap only at a sample boundary while running, so no sample mixes banks.
   assign swap = pend_q && ((state_q != RUN) || sam_clk_en);

   assign rd_data = rd_ok ? bank_q[bank_sel_q][rd_addr] : '0;

   always_comb begin
      state_d    = state_q;
      phase_d    = 2'd0;
      bank_sel_d = bank_sel_q;
      pend_d     = pend_q;
      err_d      = err_q;
      bank_d     = bank_q;

      unique case (state_q)
         IDLE: begin
            if (enable) state_d = SYNC;
         end
         SYNC: begin
            state_d = enable ? RUN : IDLE;
         end
         RUN: begin
            if (enable) phase_d = phase_q + 2'd1;
            else        state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (wr_hs && wr_ok) bank_d[~bank_sel_q][cfg_addr] = cfg_data;
      if (wr_hs && !wr_ok) err_d = 1'b1;

      if (swap) begin
         bank_sel_d = ~bank_sel_q;
         pend_d     = 1'b0;
      end
      if (cfg_commit && cfg_ready) pend_d = 1'b1;
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q    <= IDLE;
         phase_q    <= 2'd0;
         bank_sel_q <= 1'b0;
         pend_q     <= 1'b0;
         err_q      <= 1'b0;
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < NCOEF; i++)
               bank_q[b][i] <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         bank_sel_q <= bank_sel_d;
         pend_q     <= pend_d;
         err_q      <= err_d;
         bank_q     <= bank_d;
      end
   end

endmodule

// File: tb/tb_gsm_ts_ctrl.sv
// Directed bench for gsm_ts_ctrl: sequencing, bank writes,
// commit/swap timing, range errors and reset priority.
module tb_gsm_ts_ctrl;

   logic               sys_clk = 1'b0;
   logic               reset;
   logic               enable;
   logic               cfg_valid;
   logic               cfg_ready;
   logic [5:0]         cfg_addr;
   logic signed [17:0] cfg_data;
   logic               cfg_commit;
   logic [5:0]         rd_addr;
   logic signed [17:0] rd_data;
   logic               sam_clk_en;
   logic [1:0]         phase;
   logic               acc_clr;
   logic               bank_sel;
   logic               cfg_err;

   int n_cmp = 0;
   int n_bad = 0;

   gsm_ts_ctrl dut (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .enable     (enable),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .cfg_commit (cfg_commit),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .sam_clk_en (sam_clk_en),
      .phase      (phase),
      .acc_clr    (acc_clr),
      .bank_sel   (bank_sel),
      .cfg_err    (cfg_err)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #2;
   endtask

   task automatic rd_chk(input string tag, input logic [5:0] a,
                         input int exp);
      rd_addr = a;
      #1;
      chk(tag, int'(rd_data), exp);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
      cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0; rd_addr = '0;
      tick(); tick();
      reset = 1'b0;

      chk("rst_phase", phase, 0);
      chk("rst_sam", sam_clk_en, 0);
      chk("rst_acc", acc_clr, 0);
      chk("rst_bank", bank_sel, 0);
      chk("rst_ready", cfg_ready, 1);
      chk("rst_err", cfg_err, 0);
      rd_chk("rst_rd0", 6'd0, 0);
      rd_chk("rst_rd50", 6'd50, 0);

      // idle write addr 50 then commit
      cfg_valid = 1'b1; cfg_addr = 6'd50; cfg_data = 18'sd39137;
      tick();
      cfg_valid = 1'b0;
      rd_chk("idle_shadow_hidden", 6'd50, 0);
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      chk("idle_pend_ready", cfg_ready, 0);
      chk("idle_pend_bank", bank_sel, 0);
      tick();
      chk("idle_swap_bank", bank_sel, 1);
      chk("idle_swap_ready", cfg_ready, 1);
      rd_chk("idle_rd50", 6'd50, 39137);

      // write and commit in the same cycle
      cfg_valid = 1'b1; cfg_addr = 6'd0; cfg_data = -18'sd7;
      cfg_commit = 1'b1;
      tick();
      cfg_valid = 1'b0; cfg_commit = 1'b0;
      chk("same_pend_ready", cfg_ready, 0);
      tick();
      chk("same_bank", bank_sel, 0);
      rd_chk("same_rd0", 6'd0, -7);
      rd_chk("same_rd50", 6'd50, 0);

      // out-of-range write
      cfg_valid = 1'b1; cfg_addr = 6'd51; cfg_data = 18'sd123;
      tick();
      cfg_valid = 1'b0;
      chk("oor_err", cfg_err, 1);
      rd_chk("oor_rd51", 6'd51, 0);
      rd_chk("oor_rd0", 6'd0, -7);
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      tick();
      chk("oor_bank", bank_sel, 1);
      rd_chk("oor_other50", 6'd50, 39137);
      rd_chk("oor_other0", 6'd0, 0);
      chk("oor_err_sticky", cfg_err, 1);

      // phase sequencing
      enable = 1'b1;
      tick();
      chk("sync_phase", phase, 0);
      chk("sync_sam", sam_clk_en, 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("run_phase%0d", i), phase, i % 4);
         chk($sformatf("run_sam%0d", i), sam_clk_en, int'(i % 4 == 3));
         chk($sformatf("run_acc%0d", i), acc_clr, int'(i % 4 == 3));
      end

      // commit at phase 0 in RUN, swap at sample boundary
      tick();
      chk("run_p0", phase, 0);
      chk("run_p0_ready", cfg_ready, 1);
      cfg_valid = 1'b1; cfg_addr = 6'd5; cfg_data = 18'sd1000;
      cfg_commit = 1'b1;
      for (int p = 1; p < 4; p++) begin
         tick();
         cfg_valid = 1'b0; cfg_commit = 1'b0;
         chk($sformatf("run_hold_ready_p%0d", p), cfg_ready, 0);
         chk($sformatf("run_hold_bank_p%0d", p), bank_sel, 1);
      end
      chk("run_p3_sam", sam_clk_en, 1);
      tick();
      chk("run_swap_phase", phase, 0);
      chk("run_swap_bank", bank_sel, 0);
      chk("run_swap_ready", cfg_ready, 1);
      rd_chk("run_swap_rd5", 6'd5, 1000);

      // enable drop cancels the pending swap until IDLE
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      enable = 1'b0;
      chk("cancel_ready", cfg_ready, 0);
      tick();
      chk("cancel_idle_phase", phase, 0);
      chk("cancel_bank_held", bank_sel, 0);
      chk("cancel_still_pend", cfg_ready, 0);
      tick();
      chk("cancel_swap_bank", bank_sel, 1);
      chk("cancel_swap_ready", cfg_ready, 1);

      // reset during a pending swap in RUN
      enable = 1'b1;
      tick();
      tick();
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      chk("rst2_pend", cfg_ready, 0);
      chk("rst2_phase_pre", phase, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      enable = 1'b0;
      chk("rst2_phase", phase, 0);
      chk("rst2_sam", sam_clk_en, 0);
      chk("rst2_bank", bank_sel, 0);
      chk("rst2_ready", cfg_ready, 1);
      chk("rst2_err", cfg_err, 0);
      rd_chk("rst2_rd50", 6'd50, 0);
      rd_chk("rst2_rd0", 6'd0, 0);
      rd_chk("rst2_rd5", 6'd5, 0);
      tick();
      chk("rst2_idle_phase", phase, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
